// File: rtl/lsu_mem_port.sv
// lsu_mem_port -- load/store unit for the multicycle RV32I core.
//
// Runs one memory transaction per start pulse over a req/ready handshake.
// Loads return byte/half/word data with sign or zero extension. Stores drive
// lane-replicated data with byte strobes. Misaligned and illegal accesses
// abort with a one-cycle fault pulse and never touch memory.
//
// Optional feature: define LSU_TIMEOUT_EN to abort an ACCESS that waits
// TIMEOUT_CYCLES cycles without mem_ready (fault cause 11).
//
// Ports:
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   start, we, funct3  request pulse, 1=store, RV32I size/sign encoding
//   addr, wdata        byte address, store data (rs2)
//   busy, done, fault  status: not idle, success pulse, abort pulse
//   rdata              extended load result, held until the next load
//   fault_cause        01 misaligned, 10 illegal funct3, 11 timeout
//   mem_*              word-aligned memory request interface
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("lsu_mem_port: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_FAULT} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  off_reg;
    logic [31:0] mem_addr_reg;
    logic [3:0]  mem_wstrb_reg;
    logic [31:0] mem_wdata_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  cause_reg;

    // Request decode, only meaningful in IDLE while start is high.
    logic        legal;
    logic        misaligned;
    logic [1:0]  req_cause;
    logic [3:0]  wstrb_fmt;
    logic [31:0] wdata_fmt;
    logic        timeout_hit;

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        req_cause  = 2'b00;
        wstrb_fmt  = 4'b0000;
        wdata_fmt  = wdata;
        if (we)
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        // Illegal encoding is reported ahead of misalignment.
        if (!legal)
            req_cause = 2'b10;
        else if (misaligned)
            req_cause = 2'b01;
        case (funct3[1:0])
            2'b00: begin
                wdata_fmt = {4{wdata[7:0]}};
                wstrb_fmt = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_fmt = {2{wdata[15:0]}};
                wstrb_fmt = 4'b0011 << addr[1:0];
            end
            default: begin
                wdata_fmt = wdata;
                wstrb_fmt = 4'b1111;
            end
        endcase
        if (!we)
            wstrb_fmt = 4'b0000;
    end

    // Load extraction from the latched offset and funct3.
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_fmt;

    always_comb begin
        case (off_reg)
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_fmt = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
            3'b100:  load_fmt = {24'd0, load_byte};
            3'b101:  load_fmt = {16'd0, load_half};
            default: load_fmt = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_reg;

    // The count equals the number of ready-less ACCESS cycles already seen,
    // so the TIMEOUT_CYCLES-th such cycle is the one where it equals LAST.
    assign timeout_hit = (state_reg == S_ACCESS) && !mem_ready &&
                         (wait_cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wait_cnt_reg <= 16'd0;
        else if (state_reg == S_IDLE)
            wait_cnt_reg <= 16'd0;
        else if (state_reg == S_ACCESS && !mem_ready)
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start)
                    state_next = (req_cause != 2'b00) ? S_FAULT : S_ACCESS;
            end
            S_ACCESS: begin
                if (mem_ready)
                    state_next = S_DONE;
                else if (timeout_hit)
                    state_next = S_FAULT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= S_IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            off_reg       <= 2'b00;
            mem_addr_reg  <= 32'd0;
            mem_wstrb_reg <= 4'b0000;
            mem_wdata_reg <= 32'd0;
            rdata_reg     <= 32'd0;
            cause_reg     <= 2'b00;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && start) begin
                we_reg        <= we;
                funct3_reg    <= funct3;
                off_reg       <= addr[1:0];
                mem_addr_reg  <= {addr[31:2], 2'b00};
                mem_wstrb_reg <= wstrb_fmt;
                mem_wdata_reg <= wdata_fmt;
                if (req_cause != 2'b00)
                    cause_reg <= req_cause;
            end
            if (state_reg == S_ACCESS && mem_ready && !we_reg)
                rdata_reg <= load_fmt;
            if (timeout_hit)
                cause_reg <= 2'b11;
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign fault       = (state_reg == S_FAULT);
    assign mem_req     = (state_reg == S_ACCESS);
    assign mem_we      = we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wstrb   = mem_wstrb_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign rdata       = rdata_reg;
    assign fault_cause = cause_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed testbench for lsu_mem_port. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int fault_cnt = 0;
    int req_cnt = 0;
    int done_base, fault_base, req_base;

    lsu_mem_port #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)    done_cnt++;
        if (fault)   fault_cnt++;
        if (mem_req) req_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the start
    // cycle with start low again.
    task automatic do_start(input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
        we = w; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("txn: we=%0b funct3=%03b addr=%h wdata=%h", w, f3, a, wd);
    endtask

    task automatic snap();
        done_base = done_cnt; fault_base = fault_cnt; req_base = req_cnt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; we = 1'b0; funct3 = 3'b000;
        addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {27'd0, busy, done, fault, mem_req, mem_we}, 32'd0);
        chk("rst_cause_strb", {26'd0, fault_cause, mem_wstrb}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // LB 0x103, ready immediately
        mem_ready = 1'b1; mem_rdata = 32'h80123456;
        do_start(1'b0, 3'b000, 32'h103, 32'd0);
        chk("lb_req", {31'd0, mem_req}, 32'd1);
        chk("lb_addr", mem_addr, 32'h100);
        chk("lb_strb", {28'd0, mem_wstrb}, 32'h0);
        chk("lb_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("lb_done", {31'd0, done}, 32'd1);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        @(negedge clk);
        chk("lb_done_clear", {30'd0, done, busy}, 32'd0);

        // LBU 0x103
        do_start(1'b0, 3'b100, 32'h103, 32'd0);
        @(negedge clk);
        chk("lbu_done", {31'd0, done}, 32'd1);
        chk("lbu_rdata", rdata, 32'h00000080);
        @(negedge clk);

        // SH 0x202
        snap();
        do_start(1'b1, 3'b001, 32'h202, 32'h1234ABCD);
        chk("sh_we", {31'd0, mem_we}, 32'd1);
        chk("sh_addr", mem_addr, 32'h200);
        chk("sh_strb", {28'd0, mem_wstrb}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hABCDABCD);
        repeat (3) @(negedge clk);
        chk("sh_done_once", done_cnt - done_base, 32'd1);
        chk("sh_rdata_kept", rdata, 32'h00000080);

        // LW misaligned 0x102
        snap();
        do_start(1'b0, 3'b010, 32'h102, 32'd0);
        chk("lw_mis_fault", {31'd0, fault}, 32'd1);
        chk("lw_mis_cause", {30'd0, fault_cause}, 32'd1);
        @(negedge clk);
        chk("lw_mis_fault_clear", {31'd0, fault}, 32'd0);
        chk("lw_mis_cause_held", {30'd0, fault_cause}, 32'd1);
        chk("lw_mis_noreq", req_cnt - req_base, 32'd0);
        chk("lw_mis_rdata_kept", rdata, 32'h00000080);

        // Illegal store funct3 011
        do_start(1'b1, 3'b011, 32'h100, 32'd0);
        chk("st011_fault", {31'd0, fault}, 32'd1);
        chk("st011_cause", {30'd0, fault_cause}, 32'd2);
        @(negedge clk);
        // Illegal load funct3 110 at a misaligned address: illegal wins
        do_start(1'b0, 3'b110, 32'h103, 32'd0);
        chk("ld110_cause", {30'd0, fault_cause}, 32'd2);
        @(negedge clk);
        chk("illegal_noreq", req_cnt - req_base, 32'd0);

        // LH 0x006 with three wait cycles and a second start mid-wait
        snap();
        mem_ready = 1'b0; mem_rdata = 32'hF00D0000;
        do_start(1'b0, 3'b001, 32'h006, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("lh_wait_req", {31'd0, mem_req}, 32'd1);
            chk("lh_wait_addr", mem_addr, 32'h004);
            chk("lh_wait_strb", {28'd0, mem_wstrb}, 32'h0);
            chk("lh_wait_done", {31'd0, done}, 32'd0);
            if (i == 0) start = 1'b1;
            if (i == 1) start = 1'b0;
            if (i == 3) mem_ready = 1'b1;
            @(negedge clk);
        end
        chk("lh_done", {31'd0, done}, 32'd1);
        chk("lh_rdata", rdata, 32'hFFFFF00D);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("lh_idle", {31'd0, busy}, 32'd0);
        chk("lh_done_once", done_cnt - done_base, 32'd1);
        chk("lh_req_cycles", req_cnt - req_base, 32'd4);

        // Reset in the middle of ACCESS
        do_start(1'b0, 3'b010, 32'h200, 32'd0);
        chk("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_ctl", {27'd0, busy, done, fault, mem_req, mem_we}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        @(negedge clk);
        resetn = 1'b1; mem_ready = 1'b1;
        snap();
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - done_base, 32'd0);
        chk("rst_mid_no_fault", fault_cnt - fault_base, 32'd0);
        do_start(1'b1, 3'b010, 32'h010, 32'hDEADBEEF);
        chk("sw_strb", {28'd0, mem_wstrb}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_addr", mem_addr, 32'h010);
        @(negedge clk);
        chk("sw_done", {31'd0, done}, 32'd1);
        @(negedge clk);

`ifdef LSU_TIMEOUT_EN
        // Timeout after four ready-less cycles
        snap();
        mem_ready = 1'b0;
        do_start(1'b0, 3'b010, 32'h300, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_req", {31'd0, mem_req}, 32'd1);
            chk("to_wait_fault", {31'd0, fault}, 32'd0);
            @(negedge clk);
        end
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_cause", {30'd0, fault_cause}, 32'd3);
        chk("to_req_low", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("to_req_cycles", req_cnt - req_base, 32'd4);
        // Ready on the fourth wait cycle completes normally
        snap();
        mem_rdata = 32'h0000CAFE;
        do_start(1'b0, 3'b010, 32'h300, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            @(negedge clk);
        end
        chk("to_late_done", {31'd0, done}, 32'd1);
        chk("to_late_rdata", rdata, 32'h0000CAFE);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("to_late_no_fault", fault_cnt - fault_base, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
